// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scanout block: register map,
// pixel modes, STATUS bit positions and default 640x480 timing.
package vga_pkg;

  localparam int unsigned CNT_W = 12;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_BASE    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_PALETTE = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_MODE   = 1;
  localparam int unsigned STAT_VBLANK = 0;
  localparam int unsigned STAT_VSYNC  = 1;

  typedef enum logic {
    MODE_RGB222 = 1'b0,
    MODE_PAL4   = 1'b1
  } vga_mode_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical position counters advancing on the pixel enable,
// with raw sync, display-area, vblank and frame/vsync start pulses.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hs,
  output logic             vs,
  output logic             da,
  output logic             vblank,
  output logic             frame_start,
  output logic             vsync_start
);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign hs          = !((hc >= HS_BEG) && (hc < HS_END));
  assign vs          = !((vc >= VS_BEG) && (vc < VS_END));
  assign da          = (hc < H_ACT) && (vc < V_ACT);
  assign vblank      = (vc >= V_ACT);
  assign frame_start = pix_ce && (hc == '0) && (vc == '0);
  assign vsync_start = pix_ce && (hc == '0) && (vc == VS_BEG);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: timing, CPU register file, two-stage framebuffer fetch
// pipeline with RGB222 / 4bpp palette decode onto the DAC pins.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned VGA_BITS   = 4
)(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pix_ce,
  input  logic                reg_we,
  input  logic [1:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic [31:0]         fb_addr,
  input  logic [31:0]         fb_data,
  output logic [VGA_BITS-1:0] vga_r,
  output logic [VGA_BITS-1:0] vga_g,
  output logic [VGA_BITS-1:0] vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_da,
  output logic                vblank_irq
);

  localparam logic [31:0] FB_W = 32'(H_ACTIVE >> SCALE_LOG2);

  logic [CNT_W-1:0] hc, vc;
  logic             t_hs, t_vs, t_da, vblank, frame_start, vsync_start;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hc(hc), .vc(vc), .hs(t_hs), .vs(t_vs), .da(t_da), .vblank(vblank),
    .frame_start(frame_start), .vsync_start(vsync_start)
  );

  logic        ctrl_en, en_live;
  vga_mode_e   ctrl_mode, mode_live;
  logic [29:0] base_w, base_live;
  logic [5:0]  palette [16];
  logic        vsync_flag;
  logic [15:0] frame_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_mode   <= MODE_RGB222;
      base_w      <= '0;
      vsync_flag  <= 1'b0;
      frame_count <= '0;
      for (int unsigned i = 0; i < 16; i++) palette[i] <= '0;
    end else begin
      if (reg_we) begin
        case (reg_addr)
          REG_CTRL: begin
            ctrl_en   <= reg_wdata[CTRL_EN];
            ctrl_mode <= vga_mode_e'(reg_wdata[CTRL_MODE]);
          end
          REG_BASE:    base_w <= reg_wdata[31:2];
          REG_PALETTE: palette[reg_wdata[19:16]] <= reg_wdata[5:0];
          default: ;
        endcase
      end
      if (vsync_start) begin
        vsync_flag  <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else if (reg_we && (reg_addr == REG_STATUS) && reg_wdata[STAT_VSYNC]) begin
        vsync_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_live   <= 1'b0;
      mode_live <= MODE_RGB222;
      base_live <= '0;
    end else if (frame_start) begin
      en_live   <= ctrl_en;
      mode_live <= ctrl_mode;
      base_live <= base_w;
    end
  end

  // The fetch for (0,0) shares its edge with the live-copy load, so it
  // must see the CPU-written values directly.
  logic        en_eff;
  vga_mode_e   mode_eff;
  logic [29:0] base_eff;
  logic [31:0] pix_idx, byte_off;

  assign en_eff   = frame_start ? ctrl_en   : en_live;
  assign mode_eff = frame_start ? ctrl_mode : mode_live;
  assign base_eff = frame_start ? base_w    : base_live;
  assign pix_idx  = 32'(vc >> SCALE_LOG2) * FB_W + 32'(hc >> SCALE_LOG2);
  assign byte_off = (mode_eff == MODE_PAL4) ? (pix_idx >> 1) : pix_idx;

  logic [2:0] s1_sel;
  vga_mode_e  s1_mode;
  logic       s1_en, s1_hs, s1_vs, s1_da;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_addr <= '0;
      s1_sel  <= '0;
      s1_mode <= MODE_RGB222;
      s1_en   <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_da   <= 1'b0;
    end else if (pix_ce) begin
      fb_addr <= {base_eff, 2'b00} + byte_off;
      s1_sel  <= pix_idx[2:0];
      s1_mode <= mode_eff;
      s1_en   <= en_eff;
      s1_hs   <= t_hs;
      s1_vs   <= t_vs;
      s1_da   <= t_da;
    end
  end

  logic [1:0] lane;
  logic [7:0] pix_byte;
  logic [3:0] nib;
  logic [5:0] colour;

  always_comb begin
    lane     = (s1_mode == MODE_PAL4) ? s1_sel[2:1] : s1_sel[1:0];
    pix_byte = fb_data[{lane, 3'b000} +: 8];
    nib      = s1_sel[0] ? pix_byte[7:4] : pix_byte[3:0];
    colour   = (s1_mode == MODE_PAL4) ? palette[nib] : pix_byte[5:0];
    if (!(s1_en && s1_da)) colour = '0;
  end

  function automatic logic [VGA_BITS-1:0] dac(input logic [1:0] f);
    logic [VGA_BITS-1:0] d;
    d = '0;
    d[VGA_BITS-1 -: 2] = f;
    return d;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_da <= 1'b0;
    end else if (pix_ce) begin
      vga_r  <= dac(colour[5:4]);
      vga_g  <= dac(colour[3:2]);
      vga_b  <= dac(colour[1:0]);
      vga_hs <= s1_hs;
      vga_vs <= s1_vs;
      vga_da <= s1_da;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_CTRL: begin
        reg_rdata[CTRL_EN]   = ctrl_en;
        reg_rdata[CTRL_MODE] = ctrl_mode;
      end
      REG_BASE: reg_rdata = {base_w, 2'b00};
      REG_STATUS: begin
        reg_rdata[31:16]       = frame_count;
        reg_rdata[STAT_VSYNC]  = vsync_flag;
        reg_rdata[STAT_VBLANK] = vblank;
      end
      default: reg_rdata = '0;
    endcase
  end

  assign vblank_irq = vsync_flag;

endmodule
